riscv_mem_arbiter: RTL
======================

// Module: riscv_mem_arbiter
// PURPOSE
//  Parametrised N-channel arbiter between cache refill/write-back ports and one external memory port.
//  Sits in the next-generation core top below the instruction/data caches (and future extra caches).
//  Replaces the separate imem/mem buses with one shared block-wide bus.
//  Round-robin grant, one transaction in flight, level request / ready-pulse handshake.
// PARAMETERS
//  NUM_CH      2     number of requesting channels (>=2); channel 0 = icache, channel 1 = dcache
//  DATA_WIDTH  128   memory block width in bits
//  S_ADDR      23    block address width (ADDR - BYTE_OFF)
//  TIMEOUT_CYC 1024  watchdog limit in cycles (used only with RISCV_ARB_TIMEOUT_EN)
// PORTS
//  i_riscv_arb_clk    in   1                clock
//  i_riscv_arb_rst    in   1                asynchronous reset, active-low
//  i_riscv_arb_rden   in   NUM_CH           per-channel read request, level, held until ready
//  i_riscv_arb_wren   in   NUM_CH           per-channel write request, level, held until ready
//  i_riscv_arb_addr   in   NUM_CH*S_ADDR    per-channel block address; channel k = [k*S_ADDR +: S_ADDR]
//  i_riscv_arb_wdata  in   NUM_CH*DATA_WIDTH per-channel write block, same packing
//  o_riscv_arb_ready  out  NUM_CH           one-hot completion pulse to the granted channel
//  o_riscv_arb_rdata  out  DATA_WIDTH       read block, broadcast to all channels
//  o_riscv_arb_mem_rden  out 1              memory read strobe
//  o_riscv_arb_mem_wren  out 1              memory write strobe
//  o_riscv_arb_mem_addr  out S_ADDR         memory block address
//  o_riscv_arb_mem_wdata out DATA_WIDTH     memory write block
//  i_riscv_arb_mem_ready in  1              memory completion, single-cycle pulse
//  i_riscv_arb_mem_rdata in  DATA_WIDTH     memory read block, valid with mem_ready
//  o_riscv_arb_timeout   out 1              sticky watchdog flag (tied 0 without RISCV_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0.
//  Reset values: mem_rden/mem_wren/mem_addr/mem_wdata/timeout=0. ready=0; rdata passes mem_rdata through.
//  Channel k requests when rden[k]|wren[k]. If both are set, the channel gets a write (wren wins).
//  FSM IDLE: on any request, pick the first requester at or above rr_ptr, wrapping modulo NUM_CH.
//   Register grant and the granted addr/wdata/op onto mem_* outputs.
//   Next state is BUSY; mem strobes rise the cycle after the request is seen.
//  FSM BUSY: mem_* outputs stay stable.
//   ready[grant] = i_mem_ready (combinational; same cycle as rdata valid).
//   On i_mem_ready: drop mem strobes next edge, set rr_ptr=(grant+1)%NUM_CH (wrap), go to RECOVER.
//  FSM RECOVER: one cycle, no grant; lets the served channel drop its request.
//   Next state is always IDLE.
//  Request withdrawn during BUSY: transaction still completes; the ready pulse is still issued.
//  i_mem_ready outside BUSY is ignored; no ready pulse.
//  Back-to-back: a channel continuously requesting is served at most once per round while others request.
//  Min occupancy: 3 cycles per transaction (IDLE grant, BUSY with immediate ready, RECOVER).
//  Async reset mid-BUSY: strobes drop immediately; the transaction is abandoned.
// CONFIGURATION
//  RISCV_ARB_TIMEOUT_EN defined: a BUSY-cycle counter, width $clog2(TIMEOUT_CYC+1), runs in BUSY.
//   At TIMEOUT_CYC cycles without mem_ready: force ready[grant]=1 with rdata=0.
//   Also set timeout=1 (sticky until reset), then go to RECOVER.
//   The counter clears on entry to BUSY.
//  RISCV_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout tied 0.
// TESTING
//  Single read: ch0 rden, addr=0x000010; mem_ready after 4 cycles, rdata=0xA5..A5.
//   -> mem_rden=1 with addr 0x10 for 4 cycles; ready=2'b01 one cycle with rdata A5..A5.
//  Collision: ch0 rden and ch1 wren in the same cycle after reset (rr_ptr=0).
//   -> ch0 served first; ch1 write follows after RECOVER; rr_ptr ends at 0.
//  Fairness: NUM_CH=4, all channels request continuously, mem_ready after 1 cycle.
//   -> grant order 0,1,2,3,0; each ready one-hot.
//  rden+wren together on ch1, wdata=0x1234.
//   -> mem_wren=1, mem_rden=0, mem_wdata=0x1234.
//  Reset mid-BUSY: assert rst low while mem_rden=1.
//   -> all mem_* = 0 the same cycle; after release, state IDLE and rr_ptr=0.
//  Timeout (TIMEOUT_EN, TIMEOUT_CYC=8): never send mem_ready.
//   -> after 8 BUSY cycles ready pulses with rdata=0; timeout=1 stays high.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - round-robin N-channel cache refill/write-back arbiter onto one memory port
// Optional BUSY watchdog enabled by defining RISCV_ARB_TIMEOUT_EN.
module riscv_mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 128,
  parameter int S_ADDR      = 23,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         i_riscv_arb_clk,
  input  logic                         i_riscv_arb_rst,
  input  logic [NUM_CH-1:0]            i_riscv_arb_rden,
  input  logic [NUM_CH-1:0]            i_riscv_arb_wren,
  input  logic [NUM_CH*S_ADDR-1:0]     i_riscv_arb_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_riscv_arb_wdata,
  output logic [NUM_CH-1:0]            o_riscv_arb_ready,
  output logic [DATA_WIDTH-1:0]        o_riscv_arb_rdata,
  output logic                         o_riscv_arb_mem_rden,
  output logic                         o_riscv_arb_mem_wren,
  output logic [S_ADDR-1:0]            o_riscv_arb_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_riscv_arb_mem_wdata,
  input  logic                         i_riscv_arb_mem_ready,
  input  logic [DATA_WIDTH-1:0]        i_riscv_arb_mem_rdata,
  output logic                         o_riscv_arb_timeout
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("riscv_mem_arbiter: NUM_CH must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    mem_rden_q, mem_rden_d;
  logic                    mem_wren_q, mem_wren_d;
  logic [S_ADDR-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_CH-1:0]       req;
  logic [S_ADDR-1:0]       ch_addr  [NUM_CH];
  logic [DATA_WIDTH-1:0]   ch_wdata [NUM_CH];
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W:0]          cand;
  logic [IDX_W-1:0]        rr_next;
  logic [NUM_CH-1:0]       grant_oh;
  logic                    expire;
  logic                    done;
  logic                    forced;

  assign req = i_riscv_arb_rden | i_riscv_arb_wren;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_addr[k]  = i_riscv_arb_addr[k*S_ADDR +: S_ADDR];
    assign ch_wdata[k] = i_riscv_arb_wdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CH)) begin
        cand = cand - (IDX_W+1)'(NUM_CH);
      end
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign rr_next  = (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
  assign grant_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_q;
  assign done     = (state_q == S_BUSY) && (i_riscv_arb_mem_ready || expire);
  assign forced   = done && !i_riscv_arb_mem_ready;

  // Completion is combinational so ready lines up with the memory's rdata beat.
  assign o_riscv_arb_ready = done ? grant_oh : '0;
  assign o_riscv_arb_rdata = forced ? '0 : i_riscv_arb_mem_rdata;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    mem_rden_d  = mem_rden_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          mem_wren_d  = i_riscv_arb_wren[pick_idx];
          mem_rden_d  = !i_riscv_arb_wren[pick_idx];
          mem_addr_d  = ch_addr[pick_idx];
          mem_wdata_d = ch_wdata[pick_idx];
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (done) begin
          mem_rden_d = 1'b0;
          mem_wren_d = 1'b0;
          rr_ptr_d   = rr_next;
          state_d    = S_RECOVER;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
    if (!i_riscv_arb_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      mem_rden_q  <= mem_rden_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_riscv_arb_mem_rden  = mem_rden_q;
  assign o_riscv_arb_mem_wren  = mem_wren_q;
  assign o_riscv_arb_mem_addr  = mem_addr_q;
  assign o_riscv_arb_mem_wdata = mem_wdata_q;

`ifdef RISCV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign expire = (state_q == S_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC));

  // Held at zero outside BUSY, so every transaction starts a fresh count.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | forced;
    if (state_q != S_BUSY) begin
      cnt_d = '0;
    end else if (!expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
    if (!i_riscv_arb_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_riscv_arb_timeout = timeout_q;
`else
  assign expire              = 1'b0;
  assign o_riscv_arb_timeout = 1'b0;
`endif

endmodule
